pipe_fetch_queue: RTL and testbench

- Instruction-fetch stage between the program counter register and the ID stage of the pipelined CPU.
- Issues instruction-memory requests at the current pc and drives wpc so the PC advances only when a request is accepted.
- Buffers in-order memory responses, paired with their pc+4, in a DEPTH-entry queue.
- Presents fetched instructions to decode over a valid/ready handshake; discards in-flight and buffered work on a control-flow flush.

---
 rtl/pipe_fetch_queue_pkg.sv | 13 +
 rtl/fetch_slot_ram.sv | 34 +++
 rtl/pipe_fetch_queue.sv | 137 +++++++++++++
 tb/tb_pipe_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch stage of the pipelined CPU.
// Holds the datapath width, the PC increment and the queue slot layout.
package pipe_fetch_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] pc4;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_ram.sv
// DEPTH-entry slot storage for the fetch queue: pc4 is written at issue time,
// inst when the matching response returns; one asynchronous read port.
module fetch_slot_ram
    import pipe_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTRW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              pc4_we,
    input  logic [PTRW-1:0]   pc4_waddr,
    input  logic [INST_W-1:0] pc4_wdata,
    input  logic              inst_we,
    input  logic [PTRW-1:0]   inst_waddr,
    input  logic [INST_W-1:0] inst_wdata,
    input  logic [PTRW-1:0]   raddr,
    output fetch_entry_t      rdata
);

    fetch_entry_t slots [DEPTH];

    // Payload only; slot validity lives in the control logic, so no reset here.
    always_ff @(posedge clk) begin
        if (pc4_we) begin
            slots[pc4_waddr].pc4 <= pc4_wdata;
        end
        if (inst_we) begin
            slots[inst_waddr].inst <= inst_wdata;
        end
    end

    assign rdata = slots[raddr];

endmodule

// File: rtl/pipe_fetch_queue.sv
// Instruction-fetch stage: issues in-order imem requests at pc, buffers the
// responses with their pc+4 and hands them to ID over valid/ready.
module pipe_fetch_queue
    import pipe_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTRW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [INST_W-1:0] pc,
    output logic              wpc,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [INST_W-1:0] id_pc4
);

    localparam int unsigned CW = PTRW + 1;
    localparam logic [CW:0] OCC_MAX = (CW+1)'(DEPTH);

    logic [PTRW-1:0]  iss_ptr, rd_ptr, rsp_ptr;
    logic [PTRW-1:0]  iss_ptr_nx, rd_ptr_nx, rsp_ptr_nx;
    logic [CW-1:0]    live_cnt, drop_cnt, out_cnt;
    logic [CW-1:0]    live_cnt_nx, drop_cnt_nx, out_cnt_nx;
    logic [DEPTH-1:0] filled, filled_nx;

    logic [CW:0]      occ;
    logic             credit;
    logic             issue;
    logic             pop;
    logic             rsp_ok;
    logic             rsp_drop;
    logic             rsp_fill;
    fetch_entry_t     head;

    assign occ    = {1'b0, live_cnt} + {1'b0, drop_cnt};
    assign credit = (occ < OCC_MAX);

    assign imem_req  = clrn & credit & ~flush;
    assign issue     = imem_req & imem_gnt;
    assign wpc       = issue;
    assign imem_addr = pc;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = imem_rvalid & (out_cnt != '0);
    assign rsp_drop = rsp_ok & (drop_cnt != '0);
    assign rsp_fill = rsp_ok & (drop_cnt == '0) & ~flush;

    assign id_valid = ~flush & filled[rd_ptr] & (live_cnt != '0);
    assign pop      = id_valid & id_ready;
    assign id_inst  = head.inst;
    assign id_pc4   = head.pc4;

    always_comb begin
        iss_ptr_nx  = iss_ptr;
        rd_ptr_nx   = rd_ptr;
        rsp_ptr_nx  = rsp_ptr;
        filled_nx   = filled;
        live_cnt_nx = live_cnt;
        drop_cnt_nx = drop_cnt;
        out_cnt_nx  = out_cnt + CW'(issue) - CW'(rsp_ok);

        if (flush) begin
            // Every request still outstanding after this cycle's response
            // belongs to the old stream, so the drop count is out_cnt_nx.
            drop_cnt_nx = out_cnt_nx;
            live_cnt_nx = '0;
            rd_ptr_nx   = iss_ptr;
            rsp_ptr_nx  = iss_ptr;
            filled_nx   = '0;
        end else begin
            live_cnt_nx = live_cnt + CW'(issue) - CW'(pop);
            drop_cnt_nx = drop_cnt - CW'(rsp_drop);
            if (issue) begin
                iss_ptr_nx         = iss_ptr + PTRW'(1);
                filled_nx[iss_ptr] = 1'b0;
            end
            if (rsp_fill) begin
                rsp_ptr_nx         = rsp_ptr + PTRW'(1);
                filled_nx[rsp_ptr] = 1'b1;
            end
            if (pop) begin
                rd_ptr_nx         = rd_ptr + PTRW'(1);
                filled_nx[rd_ptr] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            iss_ptr  <= '0;
            rd_ptr   <= '0;
            rsp_ptr  <= '0;
            filled   <= '0;
            live_cnt <= '0;
            drop_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            iss_ptr  <= iss_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            rsp_ptr  <= rsp_ptr_nx;
            filled   <= filled_nx;
            live_cnt <= live_cnt_nx;
            drop_cnt <= drop_cnt_nx;
            out_cnt  <= out_cnt_nx;
        end
    end

    fetch_slot_ram #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_slots (
        .clk        (clk),
        .pc4_we     (issue),
        .pc4_waddr  (iss_ptr),
        .pc4_wdata  (pc + PC_INC),
        .inst_we    (rsp_fill),
        .inst_waddr (rsp_ptr),
        .inst_wdata (imem_rdata),
        .raddr      (rd_ptr),
        .rdata      (head)
    );

    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (!clrn) imem_rvalid |-> (out_cnt != '0));

    a_occ_bound: assert property (
        @(posedge clk) disable iff (!clrn) occ <= OCC_MAX);

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue: reset, stall-on-full, flush drops,
// pc wrap, plus a cycle-level reference model of memory and the queue.
module tb_pipe_fetch_queue;
    import pipe_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int unsigned gen;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] addr;
        bit          filled;
    } xent_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] pc;
    logic        wpc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;

    always #5 clk = ~clk;

    pipe_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .pc          (pc),
        .wpc         (wpc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc4      (id_pc4)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned gen    = 0;
    int unsigned lat_lo = 1;
    int unsigned lat_hi = 1;
    int unsigned n;
    logic [31:0] flush_target;

    mreq_t mem_q [$];
    xent_t exp_q [$];

    logic        s_req, s_wpc, s_valid;
    logic [31:0] s_addr, s_inst, s_pc4;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive memory, sample at the falling edge, advance models.
    task automatic cycle();
        int unsigned n_old;
        int unsigned lat;
        logic        e_req, e_valid, m_issue, m_pop;
        mreq_t       r;
        imem_rvalid = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_rdata  = imem_rvalid ? ~mem_q[0].addr : '0;
        n_old = 0;
        foreach (mem_q[i]) if (mem_q[i].gen != gen) n_old++;
        e_req   = !flush && ((exp_q.size() + n_old) < DEPTH);
        e_valid = !flush && (exp_q.size() != 0) && exp_q[0].filled;
        #4;
        s_req   = imem_req;
        s_wpc   = wpc;
        s_valid = id_valid;
        s_addr  = imem_addr;
        s_inst  = id_inst;
        s_pc4   = id_pc4;
        check("req", s_req, e_req);
        check("wpc", s_wpc, e_req & imem_gnt);
        check("valid", s_valid, e_valid);
        check("addr", s_addr, pc);
        check("occ", (dut.live_cnt + dut.drop_cnt) <= DEPTH, 1);
        if (e_valid && id_ready) begin
            check("pc4", s_pc4, exp_q[0].addr + 32'd4);
            check("inst", s_inst, ~exp_q[0].addr);
        end
        m_issue = e_req & imem_gnt;
        m_pop   = e_valid & id_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (imem_rvalid) begin
            r = mem_q.pop_front();
            if (r.gen == gen) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (m_pop) void'(exp_q.pop_front());
        if (m_issue) begin
            lat = $urandom_range(lat_hi, lat_lo);
            mem_q.push_back('{addr: pc, gen: gen, due: cyc + lat - 1});
            exp_q.push_back('{addr: pc, filled: 1'b0});
        end
        if (flush) begin
            gen++;
            exp_q.delete();
            pc = flush_target;
        end else if (m_issue) begin
            pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        clrn        = 1'b0;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        id_ready    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pc          = start_pc;
        mem_q.delete();
        exp_q.delete();
        gen = 0;
        #2;
        check("rst_req", imem_req, 0);
        check("rst_wpc", wpc, 0);
        check("rst_valid", id_valid, 0);
        @(posedge clk);
        #1;
        cyc++;
        check("rst_live", dut.live_cnt, 0);
        check("rst_drop", dut.drop_cnt, 0);
        clrn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; pc = '0; flush_target = '0;
        @(posedge clk);
        #1;

        // Streaming with 1-cycle memory: first valid two cycles after reset.
        do_reset(32'h0);
        id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("t1_wpc", s_wpc, 1);
            check("t1_valid", s_valid, 32'(k >= 2));
            if (k >= 2) check("t1_pc4", s_pc4, 32'(4 * (k - 1)));
        end

        // ID stalled: four issues fill the queue, then PC holds.
        do_reset(32'h0);
        for (int k = 0; k < 7; k++) begin
            cycle();
            check("t2_wpc", s_wpc, 32'(k < 4));
            if (k >= 4) check("t2_req", s_req, 0);
        end
        id_ready = 1'b1;
        cycle();
        check("t2_pop_valid", s_valid, 1);
        check("t2_pop_pc4", s_pc4, 32'h4);
        check("t2_pop_wpc", s_wpc, 0);
        cycle();
        check("t2_resume_wpc", s_wpc, 1);
        check("t2_resume_addr", s_addr, 32'h10);
        check("t2_resume_pc4", s_pc4, 32'h8);

        // Latency 4, three outstanding, flush to 0x400.
        do_reset(32'h0);
        id_ready = 1'b1;
        lat_lo = 4; lat_hi = 4;
        repeat (3) cycle();
        flush = 1'b1; flush_target = 32'h400;
        cycle();
        check("t3_flush_req", s_req, 0);
        check("t3_flush_valid", s_valid, 0);
        check("t3_drop", dut.drop_cnt, 3);
        check("t3_live", dut.live_cnt, 0);
        flush = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 20);
        check("t3_wait", n, 6);
        check("t3_pc4", s_pc4, 32'h404);
        check("t3_inst", s_inst, ~32'h400);

        // Flush coinciding with a response and a ready ID stage.
        do_reset(32'h0);
        id_ready = 1'b1;
        lat_lo = 1; lat_hi = 1;
        repeat (2) cycle();
        flush = 1'b1; flush_target = 32'h200;
        cycle();
        check("t4_valid", s_valid, 0);
        check("t4_req", s_req, 0);
        check("t4_live", dut.live_cnt, 0);
        check("t4_drop", dut.drop_cnt, 0);
        flush = 1'b0; imem_gnt = 1'b0;
        repeat (2) begin
            cycle();
            check("t4_idle_valid", s_valid, 0);
            check("t4_idle_req", s_req, 1);
        end
        imem_gnt = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!s_valid && n < 20);
        check("t4_wait", n, 3);
        check("t4_pc4", s_pc4, 32'h204);
        check("t4_inst", s_inst, ~32'h200);

        // pc+4 wraps to zero.
        do_reset(32'hFFFF_FFFC);
        id_ready = 1'b1;
        repeat (2) cycle();
        cycle();
        check("t5_valid", s_valid, 1);
        check("t5_pc4", s_pc4, 32'h0);
        check("t5_inst", s_inst, 32'h3);

        // Random grant, latency 1-5, ID stalls and occasional flushes.
        do_reset(32'h1000);
        lat_lo = 1; lat_hi = 5;
        for (int k = 0; k < 800; k++) begin
            imem_gnt     = ($urandom_range(9, 0) < 7);
            id_ready     = ($urandom_range(9, 0) < 7);
            flush        = ($urandom_range(39, 0) == 0);
            flush_target = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b1;
        repeat (30) cycle();
        check("t6_empty_valid", s_valid, 0);
        check("t6_empty_live", dut.live_cnt, 0);
        check("t6_empty_out", dut.out_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
